// File: rtl/depth_test_issuer.sv
// depth_test_issuer: buffers rasterized fragments in a small FIFO, issues them
// one at a time to the depth-test unit, waits for the pass/fail verdict and
// emits passing fragments as single-cycle framebuffer pixel writes.
// Optional feature: define FRAG_STATS_EN to add saturating pass/fail verdict
// counters (pass_count_out, fail_count_out).
module depth_test_issuer #(
   parameter int DEPTH_WIDTH = 16,
   parameter int COLOR_WIDTH = 16,
   parameter int FIFO_DEPTH  = 8,
   parameter int TIMEOUT     = 64
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   frag_valid_in,
   output logic                   frag_ready_out,
   input  logic [31:0]            frag_addr_in,
   input  logic [DEPTH_WIDTH-1:0] frag_depth_in,
   input  logic [COLOR_WIDTH-1:0] frag_color_in,
   output logic                   dt_valid_out,
   input  logic                   dt_ready_in,
   output logic [31:0]            dt_addr_out,
   output logic [DEPTH_WIDTH-1:0] dt_depth_out,
   input  logic                   dt_done_in,
   input  logic                   dt_pass_in,
   output logic                   px_valid_out,
   output logic [31:0]            px_addr_out,
   output logic [COLOR_WIDTH-1:0] px_color_out,
   output logic                   busy_out,
   output logic                   timeout_out
`ifdef FRAG_STATS_EN
   ,
   output logic [31:0]            pass_count_out,
   output logic [31:0]            fail_count_out
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef struct packed {
      logic [31:0]            addr;
      logic [DEPTH_WIDTH-1:0] depth;
      logic [COLOR_WIDTH-1:0] color;
   } frag_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_EMIT
   } state_t;

   frag_t           mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   frag_t           head;
   logic            push;
   logic            pop;

   state_t          state;
   logic [31:0]     held_addr;
   logic [COLOR_WIDTH-1:0] held_color;
   logic [TW-1:0]   wait_cnt;

   assign head           = mem[rd_ptr];
   assign frag_ready_out = (count != CW'(FIFO_DEPTH));
   assign push           = frag_valid_in && frag_ready_out;
   assign pop            = (state == S_IDLE) && (count != '0);
   assign busy_out       = (count != '0) || (state != S_IDLE);

   // FIFO storage: written on push only.
   // NOTE: the storage array has no reset; occupancy and pointers define which
   // entries are live, so clearing the data would only cost logic.
   always_ff @(posedge clk_in) begin
      if (push) begin
         mem[wr_ptr] <= '{addr: frag_addr_in, depth: frag_depth_in, color: frag_color_in};
      end
   end

   // FIFO pointers and occupancy; simultaneous push and pop leaves count unchanged.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Issue FSM with registered handshake and pixel-write outputs.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state        <= S_IDLE;
         held_addr    <= '0;
         held_color   <= '0;
         wait_cnt     <= '0;
         dt_valid_out <= 1'b0;
         dt_addr_out  <= '0;
         dt_depth_out <= '0;
         px_valid_out <= 1'b0;
         px_addr_out  <= '0;
         px_color_out <= '0;
         timeout_out  <= 1'b0;
      end else begin
         px_valid_out <= 1'b0;
         case (state)
            S_IDLE: begin
               if (pop) begin
                  held_addr    <= head.addr;
                  held_color   <= head.color;
                  dt_addr_out  <= head.addr;
                  dt_depth_out <= head.depth;
                  dt_valid_out <= 1'b1;
                  state        <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (dt_ready_in) begin
                  dt_valid_out <= 1'b0;
                  wait_cnt     <= '0;
                  state        <= S_WAIT;
               end
            end
            S_WAIT: begin
               wait_cnt <= wait_cnt + TW'(1);
               // A verdict on the expiry cycle takes priority over the timeout.
               if (dt_done_in) begin
                  if (dt_pass_in) begin
                     px_valid_out <= 1'b1;
                     px_addr_out  <= held_addr;
                     px_color_out <= held_color;
                     state        <= S_EMIT;
                  end else begin
                     state <= S_IDLE;
                  end
               end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                  timeout_out <= 1'b1;
                  state       <= S_IDLE;
               end
            end
            S_EMIT: begin
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef FRAG_STATS_EN
   // Saturating verdict counters; timeouts are counted as neither.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         pass_count_out <= '0;
         fail_count_out <= '0;
      end else if (state == S_WAIT && dt_done_in) begin
         if (dt_pass_in) begin
            if (pass_count_out != '1) pass_count_out <= pass_count_out + 32'd1;
         end else begin
            if (fail_count_out != '1) fail_count_out <= fail_count_out + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_depth_test_issuer.sv
// Directed testbench for depth_test_issuer (default parameters).
module tb_depth_test_issuer;

   localparam int DW = 16;
   localparam int CLW = 16;
   localparam int TMO = 64;

   logic           clk_in = 1'b0;
   logic           rst_in;
   logic           frag_valid_in;
   logic           frag_ready_out;
   logic [31:0]    frag_addr_in;
   logic [DW-1:0]  frag_depth_in;
   logic [CLW-1:0] frag_color_in;
   logic           dt_valid_out;
   logic           dt_ready_in;
   logic [31:0]    dt_addr_out;
   logic [DW-1:0]  dt_depth_out;
   logic           dt_done_in;
   logic           dt_pass_in;
   logic           px_valid_out;
   logic [31:0]    px_addr_out;
   logic [CLW-1:0] px_color_out;
   logic           busy_out;
   logic           timeout_out;
`ifdef FRAG_STATS_EN
   logic [31:0]    pass_count_out;
   logic [31:0]    fail_count_out;
`endif

   int total = 0;
   int bad = 0;

   // Monitors sampled on the falling edge, away from the active edge.
   int            px_cnt = 0;
   logic [31:0]   last_px_addr = '0;
   logic [DW-1:0] xfer_depth = '0;

   depth_test_issuer #(
      .DEPTH_WIDTH(DW), .COLOR_WIDTH(CLW), .FIFO_DEPTH(8), .TIMEOUT(TMO)
   ) dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .frag_valid_in(frag_valid_in), .frag_ready_out(frag_ready_out),
      .frag_addr_in(frag_addr_in), .frag_depth_in(frag_depth_in),
      .frag_color_in(frag_color_in),
      .dt_valid_out(dt_valid_out), .dt_ready_in(dt_ready_in),
      .dt_addr_out(dt_addr_out), .dt_depth_out(dt_depth_out),
      .dt_done_in(dt_done_in), .dt_pass_in(dt_pass_in),
      .px_valid_out(px_valid_out), .px_addr_out(px_addr_out),
      .px_color_out(px_color_out),
      .busy_out(busy_out), .timeout_out(timeout_out)
`ifdef FRAG_STATS_EN
      , .pass_count_out(pass_count_out), .fail_count_out(fail_count_out)
`endif
   );

   always #5 clk_in = ~clk_in;

   always @(negedge clk_in) begin
      if (px_valid_out) begin
         px_cnt       <= px_cnt + 1;
         last_px_addr <= px_addr_out;
      end
      if (dt_valid_out && dt_ready_in) xfer_depth <= dt_depth_out;
   end

   // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic push_one(input logic [31:0] a, input logic [DW-1:0] d, input logic [CLW-1:0] c);
      frag_valid_in = 1'b1;
      frag_addr_in  = a;
      frag_depth_in = d;
      frag_color_in = c;
      step();
      frag_valid_in = 1'b0;
   endtask

   // Push one fragment and answer it: verdict 1 = pass, 0 = fail, 2 = no verdict.
   task automatic run_frag(input logic [31:0] a, input int verdict);
      bit seen;
      dt_ready_in = 1'b1;
      push_one(a, DW'(a), CLW'(a));
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         if (dt_valid_out) seen = 1'b1;
         else step();
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL run_frag_issue: dt_valid_out never rose for addr %h", a);
      end
      step();
      if (verdict < 2) begin
         step();
         dt_done_in = 1'b1;
         dt_pass_in = (verdict == 1);
         step();
         dt_done_in = 1'b0;
         dt_pass_in = 1'b0;
      end else begin
         repeat (TMO) step();
      end
      step();
   endtask

   task automatic test_reset();
      rst_in = 1'b1;
      step();
      step();
      rst_in = 1'b0;
      total++; if (frag_ready_out !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", frag_ready_out); end
      total++; if (dt_valid_out !== 1'b0) begin bad++; $display("FAIL reset_dt_valid: got %b want 0", dt_valid_out); end
      total++; if (dt_addr_out !== 32'h0 || dt_depth_out !== 16'h0) begin bad++; $display("FAIL reset_dt_data: got %h/%h want 0/0", dt_addr_out, dt_depth_out); end
      total++; if (px_valid_out !== 1'b0 || px_addr_out !== 32'h0 || px_color_out !== 16'h0) begin bad++; $display("FAIL reset_px: got %b/%h/%h want 0/0/0", px_valid_out, px_addr_out, px_color_out); end
      total++; if (busy_out !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_out); end
      total++; if (timeout_out !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %b want 0", timeout_out); end
   endtask

   task automatic test_pass();
      int px0 = px_cnt;
      dt_ready_in = 1'b1;
      push_one(32'h10, 16'd5, 16'hF800);             // edge N
      total++; if (dt_valid_out !== 1'b0 || busy_out !== 1'b1) begin bad++; $display("FAIL pass_after_push: valid=%b busy=%b want 0/1", dt_valid_out, busy_out); end
      step();                                       // edge N+1: pop
      total++; if (dt_valid_out !== 1'b1 || dt_addr_out !== 32'h10 || dt_depth_out !== 16'd5) begin bad++; $display("FAIL pass_issue: valid=%b addr=%h depth=%h want 1/10/5", dt_valid_out, dt_addr_out, dt_depth_out); end
      step();                                       // edge N+2: transfer
      total++; if (dt_valid_out !== 1'b0) begin bad++; $display("FAIL pass_xfer: dt_valid_out=%b want 0", dt_valid_out); end
      step();
      dt_done_in = 1'b1; dt_pass_in = 1'b1;
      step();                                       // edge M: verdict
      dt_done_in = 1'b0; dt_pass_in = 1'b0;
      total++; if (px_valid_out !== 1'b1 || px_addr_out !== 32'h10 || px_color_out !== 16'hF800) begin bad++; $display("FAIL pass_px: valid=%b addr=%h color=%h want 1/10/f800", px_valid_out, px_addr_out, px_color_out); end
      step();
      total++; if (px_valid_out !== 1'b0 || busy_out !== 1'b0) begin bad++; $display("FAIL pass_after: px_valid=%b busy=%b want 0/0", px_valid_out, busy_out); end
      step();
      total++; if (px_cnt - px0 !== 1) begin bad++; $display("FAIL pass_px_count: got %0d want 1", px_cnt - px0); end
   endtask

   task automatic test_fail();
      int px0 = px_cnt;
      dt_ready_in = 1'b1;
      push_one(32'h10, 16'd5, 16'hF800);
      step();
      step();
      total++; if (xfer_depth !== 16'd5) begin bad++; $display("FAIL fail_xfer_depth: got %h want 5", xfer_depth); end
      step();
      dt_done_in = 1'b1; dt_pass_in = 1'b0;
      step();
      dt_done_in = 1'b0;
      total++; if (px_valid_out !== 1'b0 || busy_out !== 1'b0) begin bad++; $display("FAIL fail_verdict: px_valid=%b busy=%b want 0/0", px_valid_out, busy_out); end
      step(); step();
      total++; if (px_cnt !== px0) begin bad++; $display("FAIL fail_px_count: got %0d want %0d", px_cnt, px0); end
   endtask

   task automatic test_backpressure();
      bit seen;
      dt_ready_in = 1'b0;
      for (int i = 0; i < 9; i++) begin
         frag_valid_in = 1'b1;
         frag_addr_in  = 32'h100 + 32'(i);
         frag_depth_in = DW'(i);
         frag_color_in = CLW'(i);
         total++; if (frag_ready_out !== 1'b1) begin bad++; $display("FAIL bp_ready_%0d: got %b want 1", i, frag_ready_out); end
         step();
      end
      frag_addr_in = 32'hDEAD;
      // frag_valid_in stays high: the full FIFO must refuse the extra fragment.
      for (int i = 0; i < 3; i++) begin
         total++; if (frag_ready_out !== 1'b0 || dt_valid_out !== 1'b1 || dt_addr_out !== 32'h100) begin bad++; $display("FAIL bp_hold_%0d: ready=%b valid=%b addr=%h want 0/1/100", i, frag_ready_out, dt_valid_out, dt_addr_out); end
         step();
      end
      frag_valid_in = 1'b0;
      dt_ready_in = 1'b1;
      for (int k = 0; k < 9; k++) begin
         seen = 1'b0;
         for (int w = 0; w < 20 && !seen; w++) begin
            if (dt_valid_out) seen = 1'b1;
            else step();
         end
         total++;
         if (!seen || dt_addr_out !== 32'h100 + 32'(k) || dt_depth_out !== DW'(k)) begin
            bad++; $display("FAIL bp_order_%0d: seen=%b addr=%h depth=%h want addr %h", k, seen, dt_addr_out, dt_depth_out, 32'h100 + 32'(k));
         end
         step();
         step();
         dt_done_in = 1'b1; dt_pass_in = 1'b1;
         step();
         dt_done_in = 1'b0; dt_pass_in = 1'b0;
         total++; if (px_valid_out !== 1'b1 || px_addr_out !== 32'h100 + 32'(k)) begin bad++; $display("FAIL bp_px_%0d: valid=%b addr=%h", k, px_valid_out, px_addr_out); end
      end
      step(); step();
      total++; if (busy_out !== 1'b0 || frag_ready_out !== 1'b1) begin bad++; $display("FAIL bp_drain: busy=%b ready=%b want 0/1", busy_out, frag_ready_out); end
   endtask

   task automatic test_timeout();
      int px0 = px_cnt;
      dt_ready_in = 1'b1;
      push_one(32'h200, 16'd7, 16'h07E0);
      step();
      step();                                       // edge T: transfer
      total++; if (dt_valid_out !== 1'b0) begin bad++; $display("FAIL to_xfer: dt_valid_out=%b want 0", dt_valid_out); end
      repeat (TMO - 1) step();                      // edge T+63
      total++; if (timeout_out !== 1'b0 || busy_out !== 1'b1) begin bad++; $display("FAIL to_early: timeout=%b busy=%b want 0/1", timeout_out, busy_out); end
      step();                                       // edge T+64
      total++; if (timeout_out !== 1'b1 || busy_out !== 1'b0) begin bad++; $display("FAIL to_expire: timeout=%b busy=%b want 1/0", timeout_out, busy_out); end
      step();
      total++; if (px_cnt !== px0) begin bad++; $display("FAIL to_no_px: got %0d want %0d", px_cnt, px0); end
      run_frag(32'h204, 1);
      total++; if (px_cnt - px0 !== 1 || last_px_addr !== 32'h204) begin bad++; $display("FAIL to_next: count=%0d addr=%h want 1/204", px_cnt - px0, last_px_addr); end
      total++; if (timeout_out !== 1'b1) begin bad++; $display("FAIL to_sticky: got %b want 1", timeout_out); end
   endtask

   task automatic test_reset_mid_wait();
      int px0 = px_cnt;
      dt_ready_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         frag_valid_in = 1'b1;
         frag_addr_in  = 32'h300 + 32'(i);
         step();
      end
      frag_valid_in = 1'b0;                         // first in WAIT, three queued
      rst_in = 1'b1;
      step();
      rst_in = 1'b0;
      dt_done_in = 1'b1; dt_pass_in = 1'b1;
      step();
      dt_done_in = 1'b0; dt_pass_in = 1'b0;
      total++; if (px_valid_out !== 1'b0) begin bad++; $display("FAIL rst_px: got %b want 0", px_valid_out); end
      total++; if (busy_out !== 1'b0 || frag_ready_out !== 1'b1 || dt_valid_out !== 1'b0) begin bad++; $display("FAIL rst_state: busy=%b ready=%b valid=%b want 0/1/0", busy_out, frag_ready_out, dt_valid_out); end
      total++; if (timeout_out !== 1'b0) begin bad++; $display("FAIL rst_timeout: got %b want 0", timeout_out); end
      step(); step(); step();
      total++; if (px_cnt !== px0 || busy_out !== 1'b0) begin bad++; $display("FAIL rst_quiet: px=%0d busy=%b want %0d/0", px_cnt, busy_out, px0); end
   endtask

`ifdef FRAG_STATS_EN
   task automatic test_stats();
      rst_in = 1'b1; step(); rst_in = 1'b0;
      run_frag(32'h400, 1);
      run_frag(32'h404, 0);
      run_frag(32'h408, 1);
      run_frag(32'h40C, 2);
      run_frag(32'h410, 0);
      run_frag(32'h414, 1);
      total++; if (pass_count_out !== 32'd3 || fail_count_out !== 32'd2) begin bad++; $display("FAIL stats: pass=%0d fail=%0d want 3/2", pass_count_out, fail_count_out); end
   endtask
`endif

   initial begin
      rst_in = 1'b1;
      frag_valid_in = 1'b0;
      frag_addr_in = '0;
      frag_depth_in = '0;
      frag_color_in = '0;
      dt_ready_in = 1'b0;
      dt_done_in = 1'b0;
      dt_pass_in = 1'b0;
      test_reset();
      test_pass();
      test_fail();
      test_backpressure();
      test_timeout();
      test_reset_mid_wait();
`ifdef FRAG_STATS_EN
      test_stats();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
